pll_lock_sequencer: RTL and testbench

// - Controller on the far end of the ECP5 EHXPLLL: drives the PLL RST pin, watches its LOCK output, and releases
//   the design reset only after the lock has been stable. Runs on the 25 MHz board clock that feeds the PLL.
// - Re-locks automatically on lock loss or lock timeout. Exposes status and counters for debug and LED display.

---
 rtl/pll_lock_sequencer_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/pll_lock_sequencer.sv | 155 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// ============================================================================
// Module   : pll_lock_sequencer_pkg
// Purpose  : State codes and helpers shared by the PLL lock sequencer and the
//            status-LED logic that decodes its state output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_lock_sequencer_pkg;

    localparam int STATE_W = 2;

    // State codes; the LED decoder relies on these exact values.
    localparam logic [STATE_W-1:0] ST_PLL_RST   = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [STATE_W-1:0] ST_STABLE    = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

    // Largest of three cycle counts, used to size the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for asynchronous status pins. Both stages
//            clear to zero on reset so a pin reads inactive until proven.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the clean output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Drives the ECP5 EHXPLLL RST pin, watches LOCK through a two-flop
//            synchroniser and releases the design reset only after the lock
//            has been stable. Re-locks on lock loss, lock timeout or restart
//            and keeps saturating loss/timeout counters for debug.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               rst_out,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   loss_count,
    output logic [CNT_W-1:0]   timeout_count
);

    // One timer serves every timed phase, so it is sized for the longest one.
    localparam int c_timer_w = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    // Terminal timer values: a phase ends on the cycle its timer reads N-1.
    localparam logic [c_timer_w-1:0] c_rst_last     = c_timer_w'(RST_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_stable_last  = c_timer_w'(STABLE_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);
    localparam logic [CNT_W-1:0]     c_cnt_one      = CNT_W'(1);

    logic                 w_lock_s;

    logic [STATE_W-1:0]   r_state;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_pll_rst;
    logic                 r_rst_out;
    logic                 r_ready;
    logic [CNT_W-1:0]     r_loss_count;
    logic [CNT_W-1:0]     r_timeout_count;

    logic [STATE_W-1:0]   w_next_state;
    logic [c_timer_w-1:0] w_next_timer;
    logic                 w_loss_evt;
    logic                 w_timeout_evt;

    // LOCK is asynchronous to the board clock; every decision uses w_lock_s.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clock),
        .rst (reset),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    // Next-state and timer decode; restart overrides every other transition.
    always_comb begin
        w_next_state  = r_state;
        w_next_timer  = r_timer + c_timer_one;
        w_loss_evt    = 1'b0;
        w_timeout_evt = 1'b0;

        if (restart) begin
            w_next_state = ST_PLL_RST;
            w_next_timer = '0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_timer == c_rst_last) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_next_timer = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_next_state = ST_STABLE;
                        w_next_timer = '0;
                    end else if (r_timer == c_timeout_last) begin
                        w_next_state  = ST_PLL_RST;
                        w_next_timer  = '0;
                        w_timeout_evt = 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A single low sample restarts the wait; no filtering here.
                    if (!w_lock_s) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_next_timer = '0;
                    end else if (r_timer == c_stable_last) begin
                        w_next_state = ST_RUN;
                        w_next_timer = '0;
                    end
                end
                ST_RUN: begin
                    // Timer parks at zero while running.
                    w_next_timer = '0;
                    if (!w_lock_s) begin
                        w_next_state = ST_PLL_RST;
                        w_loss_evt   = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_PLL_RST;
                    w_next_timer = '0;
                end
            endcase
        end
    end

    // State, timer, counters and outputs; outputs decode the next state so
    // they change in the same update as the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_PLL_RST;
            r_timer         <= '0;
            r_pll_rst       <= 1'b1;
            r_rst_out       <= 1'b1;
            r_ready         <= 1'b0;
            r_loss_count    <= '0;
            r_timeout_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_pll_rst <= (w_next_state == ST_PLL_RST);
            r_rst_out <= (w_next_state != ST_RUN);
            r_ready   <= (w_next_state == ST_RUN);
            if (w_loss_evt && (r_loss_count != '1)) begin
                r_loss_count <= r_loss_count + c_cnt_one;
            end
            if (w_timeout_evt && (r_timeout_count != '1)) begin
                r_timeout_count <= r_timeout_count + c_cnt_one;
            end
        end
    end

    assign pll_rst       = r_pll_rst;
    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign state         = r_state;
    assign loss_count    = r_loss_count;
    assign timeout_count = r_timeout_count;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Directed scenarios plus randomized lock/restart/reset traffic for
//            pll_lock_sequencer, checked against a phase/age reference model
//            and against fixed expected cycle numbers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 4;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pll_locked;
    logic             restart;
    logic             pll_rst;
    logic             rst_out;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] loss_count;
    logic [CNT_W-1:0] timeout_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: phase number, cycles spent in the phase, counters and
    // the two-sample delay line that stands in for the synchroniser.
    int m_phase;
    int m_age;
    int m_loss;
    int m_tmo;
    bit m_s1;
    bit m_s2;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .rst_out       (rst_out),
        .ready         (ready),
        .state         (state),
        .loss_count    (loss_count),
        .timeout_count (timeout_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, pll_rst, rst_out, ready, state, loss_count, timeout_count};
    endfunction

    function automatic logic [31:0] model_vec();
        return {19'd0, (m_phase == 0), (m_phase != 3), (m_phase == 3),
                2'(m_phase), 4'(m_loss), 4'(m_tmo)};
    endfunction

    task automatic enter(input int phase);
        m_phase = phase;
        m_age   = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        bit lock_s;
        if (reset) begin
            enter(0);
            m_loss = 0;
            m_tmo  = 0;
            m_s1   = 1'b0;
            m_s2   = 1'b0;
            return;
        end
        lock_s = m_s2;
        m_s2   = m_s1;
        m_s1   = pll_locked;
        if (restart) begin
            enter(0);
        end else begin
            case (m_phase)
                0: if (m_age + 1 == RST_CYCLES) enter(1); else m_age++;
                1: begin
                    if (lock_s) enter(2);
                    else if (m_age + 1 == LOCK_TIMEOUT) begin
                        enter(0);
                        if (m_tmo < CNT_MAX) m_tmo++;
                    end else m_age++;
                end
                2: begin
                    if (!lock_s) enter(1);
                    else if (m_age + 1 == STABLE_CYCLES) enter(3);
                    else m_age++;
                end
                default: begin
                    if (!lock_s) begin
                        enter(0);
                        if (m_loss < CNT_MAX) m_loss++;
                    end
                end
            endcase
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state === s), 32'd1);
    endtask

    // Reset pulse; afterwards cyc numbers the first post-reset cycle as 1.
    task automatic apply_reset();
        reset   = 1'b1;
        restart = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 1;
    endtask

    initial begin
        int d;
        int s;
        int k;
        int span;

        reset      = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b0;
        m_phase = 0; m_age = 0; m_loss = 0; m_tmo = 0; m_s1 = 1'b0; m_s2 = 1'b0;

        // ---- Bring-up: lock arrives at cycle 10 and is held ----
        apply_reset();
        check("reset_vec", dut_vec(), 32'h1800);
        while (cyc < 22) begin
            if (cyc == 10) pll_locked = 1'b1;
            tick();
            if (cyc <= 5)  check("t1_pll_rst", 32'(pll_rst), 32'(cyc <= 4));
            if (cyc == 12) check("t1_wait_at_12", 32'(state), 32'd1);
            if (cyc == 13) check("t1_stable_at_13", 32'(state), 32'd2);
            if (cyc == 20) check("t1_held_at_20", 32'({rst_out, ready}), 32'b10);
            if (cyc == 21) check("t1_run_at_21", 32'({rst_out, ready}), 32'b01);
        end

        // ---- One-cycle lock drop in RUN ----
        d = cyc;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            tick();
            if (i == 2)  check("t3_still_run", 32'(rst_out), 32'd0);
            if (i == 3)  check("t3_loss_vec", dut_vec(), 32'h1810);
            if (i == 7)  check("t3_wait", 32'(state), 32'd1);
            if (i == 15) check("t3_stable_end", 32'({state, ready}), 32'b100);
            if (i == 16) check("t3_rerun", 32'({state, ready, loss_count}), 32'b11_1_0001);
        end
        check("t3_elapsed", 32'(cyc - d), 32'd16);

        // ---- restart coincident with lock_s falling, then restart in PLL_RST ----
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t5_restart_vec", dut_vec(), 32'h1810);
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            tick();
            if (i == 8) check("t5_pulse_extended", 32'(pll_rst), 32'd1);
            if (i == 9) check("t5_pulse_end", 32'({pll_rst, state}), 32'b0_01);
        end

        // ---- Lock glitch during STABLE ----
        wait_state(2'd2, 10, "t4_reach_stable");
        s = cyc;
        for (int i = 1; i <= 4; i++) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int i = 6; i <= 16; i++) begin
            tick();
            if (i == 6)  check("t4_still_stable", 32'(state), 32'd2);
            if (i == 7)  check("t4_back_to_wait", 32'({state, loss_count, timeout_count}), 32'b01_0001_0000);
            if (i == 8)  check("t4_stable_again", 32'(state), 32'd2);
            if (i == 15) check("t4_not_yet_run", 32'({state, ready}), 32'b100);
            if (i == 16) check("t4_run", 32'({state, ready}), 32'b111);
        end
        check("t4_elapsed", 32'(cyc - s), 32'd16);

        // ---- Reset asserted mid-STABLE clears everything ----
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t6_no_loss_on_restart", 32'(loss_count), 32'd1);
        wait_state(2'd2, 40, "t6_reach_stable");
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        check("t6_reset_vec", dut_vec(), 32'h1800);
        reset = 1'b0;
        tick();
        check("t6_after_reset", dut_vec(), 32'h1800);

        // ---- Lock never arrives: periodic timeouts, counter saturates ----
        pll_locked = 1'b0;
        apply_reset();
        while (cyc < 1 + 36 * 16) begin
            tick();
            if (cyc > 1 && (cyc - 1) % 36 == 0) begin
                k = (cyc - 1) / 36;
                check("t2_repulse", 32'(pll_rst), 32'd1);
                check("t2_tmo_count", 32'(timeout_count), 32'((k > CNT_MAX) ? CNT_MAX : k));
            end
            if (cyc % 36 == 0) check("t2_wait_last", 32'(pll_rst), 32'd0);
        end

        // ---- Randomized lock spans, restarts and occasional resets ----
        pll_locked = 1'b1;
        apply_reset();
        span = 0;
        for (int i = 0; i < 4000; i++) begin
            if (span == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                if (pll_locked)
                    span = $urandom_range(1, 60);
                else if ($urandom_range(0, 4) == 0)
                    span = $urandom_range(30, 80);
                else
                    span = $urandom_range(1, 4);
            end
            span--;
            restart = ($urandom_range(0, 63) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset   = 1'b0;
        restart = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
